// File: rtl/btn_pkg.sv
// Shared constants and helpers for the push-button debounce block.
// Imported by btn_debounce and btn_debounce_ch.
package btn_pkg;

  localparam int NBTN_DEF       = 4;
  localparam int DIV_W_DEF      = 17;
  localparam int SAMPLES_DEF    = 4;
  localparam int LONG_TICKS_DEF = 768;

  // The long counter saturates at LONG_TICKS-1, so clog2(LONG_TICKS) bits hold it.
  function automatic int long_cnt_w(input int long_ticks);
    if (long_ticks <= 2) return 1;
    return $clog2(long_ticks);
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: sample shift register, debounced level, press/release pulses
// and, when BTN_DEBOUNCE_LONGPRESS_EN is defined, a saturating long-press counter.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int SAMPLES    = SAMPLES_DEF,
  parameter int LONG_TICKS = LONG_TICKS_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic smp_i,
  output logic lvl_o,
  output logic press_o,
  output logic rel_o,
  output logic long_o
);

  logic [SAMPLES-1:0] sr_q, sr_d, sr_shift;
  logic               lvl_q, lvl_d;
  logic               press_q, press_d;
  logic               rel_q, rel_d;

  assign sr_shift = {sr_q[SAMPLES-2:0], smp_i};

  // Level changes only on a full run of equal samples, judged on the post-shift contents.
  always_comb begin
    sr_d    = sr_q;
    lvl_d   = lvl_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    if (tick_i) begin
      sr_d = sr_shift;
      if ((&sr_shift) && !lvl_q) begin
        lvl_d   = 1'b1;
        press_d = 1'b1;
      end else if (!(|sr_shift) && lvl_q) begin
        lvl_d = 1'b0;
        rel_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr_q    <= '0;
      lvl_q   <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      lvl_q   <= lvl_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign lvl_o   = lvl_q;
  assign press_o = press_q;
  assign rel_o   = rel_q;

`ifdef BTN_DEBOUNCE_LONGPRESS_EN
  localparam int CW = long_cnt_w(LONG_TICKS);
  localparam logic [CW-1:0] LAST = CW'(LONG_TICKS - 1);

  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          long_q, long_d;

  assign cnt_inc = cnt_q + CW'(1);

  // Counter stops at LAST, so the pulse fires once per held press.
  always_comb begin
    cnt_d  = cnt_q;
    long_d = 1'b0;
    if (!lvl_q) begin
      cnt_d = '0;
    end else if (tick_i && (cnt_q != LAST)) begin
      cnt_d = cnt_inc;
      if (cnt_inc == LAST) long_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      long_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      long_q <= long_d;
    end
  end

  assign long_o = long_q;
`else
  assign long_o = 1'b0;
`endif

endmodule

// File: rtl/btn_debounce.sv
// Push-button input path: 2-FF synchroniser, shared prescaler tick and NBTN debounce channels.
// Long-press detection is built only when BTN_DEBOUNCE_LONGPRESS_EN is defined.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int NBTN       = NBTN_DEF,
  parameter int DIV_W      = DIV_W_DEF,
  parameter int SAMPLES    = SAMPLES_DEF,
  parameter int LONG_TICKS = LONG_TICKS_DEF
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NBTN-1:0] BTN,
  output logic [NBTN-1:0] BTN_LVL,
  output logic [NBTN-1:0] BTN_PRESS,
  output logic [NBTN-1:0] BTN_REL,
  output logic [NBTN-1:0] BTN_LONG,
  output logic            TICK
);

  logic [NBTN-1:0]  sync1_q, sync2_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_int;
  logic             tick_q;

  assign div_d    = div_q + DIV_W'(1);
  assign tick_int = &div_q;

  // Channels act on the internal strobe; the exported TICK is its registered copy.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q <= '0;
      sync2_q <= '0;
      div_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      sync1_q <= BTN;
      sync2_q <= sync1_q;
      div_q   <= div_d;
      tick_q  <= tick_int;
    end
  end

  assign TICK = tick_q;

  for (genvar i = 0; i < NBTN; i++) begin : g_ch
    btn_debounce_ch #(
      .SAMPLES   (SAMPLES),
      .LONG_TICKS(LONG_TICKS)
    ) u_ch (
      .clk_i  (CLK),
      .rst_i  (RST),
      .tick_i (tick_int),
      .smp_i  (sync2_q[i]),
      .lvl_o  (BTN_LVL[i]),
      .press_o(BTN_PRESS[i]),
      .rel_o  (BTN_REL[i]),
      .long_o (BTN_LONG[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Randomised and directed bench for btn_debounce with a run-length reference model.
module tb_btn_debounce;

  localparam int NBTN  = 4;
  localparam int DIV_W = 3;
  localparam int SMP   = 4;
  localparam int LT    = 16;
  localparam int TPER  = 1 << DIV_W;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic [NBTN-1:0] BTN = '0;
  logic [NBTN-1:0] BTN_LVL, BTN_PRESS, BTN_REL, BTN_LONG;
  logic            TICK;

  btn_debounce #(
    .NBTN(NBTN), .DIV_W(DIV_W), .SAMPLES(SMP), .LONG_TICKS(LT)
  ) dut (
    .CLK(CLK), .RST(RST), .BTN(BTN),
    .BTN_LVL(BTN_LVL), .BTN_PRESS(BTN_PRESS), .BTN_REL(BTN_REL),
    .BTN_LONG(BTN_LONG), .TICK(TICK)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counts edges since reset, derives the sampled value from the raw
  // input two edges back, and accepts a level on a run of SMP equal samples.
  int              e;
  logic [NBTN-1:0] prev1, prev2, samp;
  logic [NBTN-1:0] m_lvl, m_press, m_rel, m_long;
  logic            m_tick;
  int              ones_run [NBTN];
  int              zeros_run[NBTN];
  int              lcnt     [NBTN];

  always @(posedge CLK) begin
    if (RST) begin
      e = 0; prev1 = '0; prev2 = '0;
      m_lvl = '0; m_press = '0; m_rel = '0; m_long = '0; m_tick = 1'b0;
      for (int i = 0; i < NBTN; i++) begin
        ones_run[i] = 0; zeros_run[i] = 0; lcnt[i] = 0;
      end
    end else begin
      e++;
      samp = prev2;
      m_press = '0; m_rel = '0; m_long = '0;
      m_tick = (e % TPER) == 0;
      if (m_tick) begin
        for (int i = 0; i < NBTN; i++) begin
          if (m_lvl[i]) begin
            if (lcnt[i] < LT - 1) begin
              lcnt[i]++;
`ifdef BTN_DEBOUNCE_LONGPRESS_EN
              if (lcnt[i] == LT - 1) m_long[i] = 1'b1;
`endif
            end
          end else begin
            lcnt[i] = 0;
          end
          if (samp[i]) begin ones_run[i]++; zeros_run[i] = 0; end
          else begin zeros_run[i]++; ones_run[i] = 0; end
          if (ones_run[i] >= SMP && !m_lvl[i]) begin
            m_lvl[i] = 1'b1; m_press[i] = 1'b1;
          end else if (zeros_run[i] >= SMP && m_lvl[i]) begin
            m_lvl[i] = 1'b0; m_rel[i] = 1'b1;
          end
        end
      end
      prev2 = prev1;
      prev1 = BTN;
    end
  end

  // Per-cycle compare plus event bookkeeping used by the directed checks.
  int cyc = 0;
  int cnt_press[NBTN], cnt_rel[NBTN], cnt_long[NBTN];
  int press_cyc[NBTN], long_cyc[NBTN];
  logic [NBTN-1:0] last_press;

  initial begin
    for (int i = 0; i < NBTN; i++) begin
      cnt_press[i] = 0; cnt_rel[i] = 0; cnt_long[i] = 0; press_cyc[i] = 0; long_cyc[i] = 0;
    end
  end

  always @(posedge CLK) begin
    #2;
    cyc++;
    if (RST) begin
      chk("rst_lvl",   32'(BTN_LVL),   32'h0);
      chk("rst_press", 32'(BTN_PRESS), 32'h0);
      chk("rst_rel",   32'(BTN_REL),   32'h0);
      chk("rst_long",  32'(BTN_LONG),  32'h0);
      chk("rst_tick",  32'(TICK),      32'h0);
    end else begin
      chk("lvl",   32'(BTN_LVL),   32'(m_lvl));
      chk("press", 32'(BTN_PRESS), 32'(m_press));
      chk("rel",   32'(BTN_REL),   32'(m_rel));
      chk("long",  32'(BTN_LONG),  32'(m_long));
      chk("tick",  32'(TICK),      32'(m_tick));
    end
    if (BTN_PRESS != 0) last_press = BTN_PRESS;
    for (int i = 0; i < NBTN; i++) begin
      if (BTN_PRESS[i]) begin cnt_press[i]++; press_cyc[i] = cyc; end
      if (BTN_REL[i])   cnt_rel[i]++;
      if (BTN_LONG[i])  begin cnt_long[i]++; long_cyc[i] = cyc; end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    int t0, p0, r0, lg0, lvl_rise;
    bit found;
    logic [NBTN-1:0] cap;

    wait_cyc(5);
    RST = 1'b0;
    wait_cyc(60);

    // Clean press on channel 0 with latency window 27..35 CLK
    p0 = cnt_press[0];
    BTN[0] = 1'b1; t0 = cyc;
    wait_cyc(60);
    chk("ch0_press_count", 32'(cnt_press[0] - p0), 32'd1);
    chk("ch0_latency_in_window",
        32'((press_cyc[0] - t0 >= 27) && (press_cyc[0] - t0 <= 35)), 32'd1);
    chk("ch0_lvl", 32'(BTN_LVL[0]), 32'd1);
    chk("ch1_no_press", 32'(cnt_press[1]), 32'd0);

    // Bounce on channel 1: 1,0,1 across consecutive ticks then hold
    p0 = cnt_press[1];
    BTN[1] = 1'b1; wait_cyc(TPER);
    BTN[1] = 1'b0; wait_cyc(TPER);
    BTN[1] = 1'b1; t0 = cyc;
    wait_cyc(80);
    chk("ch1_bounce_press_count", 32'(cnt_press[1] - p0), 32'd1);
    chk("ch1_bounce_late_enough", 32'(press_cyc[1] - t0 >= 27), 32'd1);

    // Release on channel 2
    BTN[2] = 1'b1; wait_cyc(60);
    p0 = cnt_press[2]; r0 = cnt_rel[2];
    BTN[2] = 1'b0; wait_cyc(60);
    chk("ch2_rel_count", 32'(cnt_rel[2] - r0), 32'd1);
    chk("ch2_no_press_on_release", 32'(cnt_press[2] - p0), 32'd0);
    chk("ch2_lvl_low", 32'(BTN_LVL[2]), 32'd0);

    // Simultaneous press of channels 0 and 3
    BTN = '0; wait_cyc(60);
    BTN = 4'h9;
    found = 1'b0; cap = '0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(posedge CLK); #3;
      if (BTN_PRESS != 0) begin found = 1'b1; cap = BTN_PRESS; end
    end
    chk("simul_seen", 32'(found), 32'd1);
    chk("simul_press_value", 32'(cap), 32'h9);

    // Long press on channel 3 (already accepted above): restart it cleanly
    BTN = '0; wait_cyc(60);
    lg0 = cnt_long[3];
    BTN[3] = 1'b1;
    wait_cyc(40 * TPER);
    lvl_rise = press_cyc[3];
`ifdef BTN_DEBOUNCE_LONGPRESS_EN
    chk("ch3_long_count", 32'(cnt_long[3] - lg0), 32'd1);
    chk("ch3_long_delay", 32'(long_cyc[3] - lvl_rise), 32'(15 * TPER));
`else
    chk("ch3_long_count", 32'(cnt_long[3] - lg0), 32'd0);
    chk("ch3_long_port_low", 32'(BTN_LONG), 32'd0);
`endif
    BTN = '0; wait_cyc(60);

    // Randomised stimulus, including sub-run glitches
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 3) == 0) BTN = 4'($urandom_range(0, 15));
      else BTN[$urandom_range(0, NBTN - 1)] ^= 1'b1;
      wait_cyc($urandom_range(1, 45));
    end

    // Reset mid-press with all buttons held
    BTN = 4'hF; wait_cyc(60);
    chk("held_lvl_before_rst", 32'(BTN_LVL), 32'hF);
    @(negedge CLK); #1;
    RST = 1'b1; #1;
    chk("async_rst_lvl",   32'(BTN_LVL),   32'h0);
    chk("async_rst_press", 32'(BTN_PRESS), 32'h0);
    chk("async_rst_long",  32'(BTN_LONG),  32'h0);
    wait_cyc(3);
    RST = 1'b0; r0 = cyc; last_press = '0;
    p0 = cnt_press[0];
    wait_cyc(50);
    chk("rearm_press_once", 32'(cnt_press[0] - p0), 32'd1);
    chk("rearm_press_value", 32'(last_press), 32'hF);
    chk("rearm_press_edge", 32'(press_cyc[0] - r0), 32'(SMP * TPER));

    BTN = '0; wait_cyc(60);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
